multichannel_sample_history: RTL
================================

Name: multichannel_sample_history

Overview:
Parametrised per-channel sample history buffer for the sampling front end. Tagged samples are written into one circular history per channel. The block tracks per-channel fill level and a sliding-window sum. It offers a registered random-access tap read port and a registered window-sum query port, and supports per-channel clear. It replaces the fixed 14x8-bit shift history with addressable, clearable storage.

Parameters:
NUM_CHANNELS, 14, number of independent channel histories (>=1)
SAMPLE_WIDTH, 8, unsigned sample width in bits
DEPTH, 10, samples retained per channel (>=2, need not be a power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  write strobe
in_channel  in  CH_W  target channel of the write
in_sample  in  SAMPLE_WIDTH  sample to store
clr_valid  in  1  per-channel clear strobe
clr_channel  in  CH_W  channel to clear
rd_req  in  1  tap read request
rd_channel  in  CH_W  channel to read
rd_tap  in  TAP_W  age index, 0 = newest
rd_valid  out  1  read response strobe
rd_data  out  SAMPLE_WIDTH  tapped sample
rd_miss  out  1  tap not yet filled or channel out of range
sum_req  in  1  window-sum query
sum_channel  in  CH_W  channel to query
sum_valid  out  1  sum response strobe
sum_data  out  SUM_W  sum of currently held samples
sum_count  out  CNT_W  number of samples held

Behaviour:
- Widths: CH_W = max(1, clog2(NUM_CHANNELS)); TAP_W = clog2(DEPTH); CNT_W = clog2(DEPTH+1); SUM_W = SAMPLE_WIDTH + CNT_W. All arithmetic is unsigned.
- Reset: all wr_ptr, count and sum registers go to 0. rd_valid, rd_data, rd_miss, sum_valid, sum_data and sum_count go to 0. Sample storage is not reset.
- Write (in_valid, channel c < NUM_CHANNELS):
  - mem[c][wr_ptr[c]] <= in_sample.
  - wr_ptr[c] wraps DEPTH-1 -> 0.
  - If count[c] < DEPTH: count[c]++ and sum[c] += in_sample.
  - If count[c] == DEPTH: count[c] stays at DEPTH and sum[c] += in_sample - mem[c][wr_ptr[c]], i.e. the evicted oldest sample is subtracted in the same cycle.
- Writes with in_channel >= NUM_CHANNELS are dropped silently.
- Clear (clr_valid, channel c): wr_ptr[c], count[c] and sum[c] go to 0; memory contents are untouched.
  - Clear beats a write to the same channel in the same cycle; that write is lost.
  - A write to a different channel in the same cycle proceeds.
- Read: latency 1.
  - rd_valid is asserted the cycle after rd_req, for exactly one cycle per request. Back-to-back requests are accepted every cycle.
  - Index = (wr_ptr[c] - 1 - rd_tap) mod DEPTH, with explicit modular wrap.
  - If rd_tap >= count[c] or c is out of range: rd_miss=1, rd_data=0.
  - Reads sample the pre-update state: a same-cycle write or clear to the same channel is not visible.
- Sum query: latency 1. sum_valid pulses the cycle after sum_req and returns the pre-update sum[c] and count[c]. An out-of-range channel returns 0/0.
- rd_data and sum_data hold their value between responses; valid strobes are the only qualifiers.
- Reset asserted mid-operation: any pending response strobe the next cycle is suppressed (0), and all channels are empty.
- Sum never overflows: DEPTH * (2^SAMPLE_WIDTH - 1) fits in SUM_W.

Decomposition:
- Package multichannel_history_pkg: width helper functions (clog2-with-min-1), default constants and derived widths (CH_W, TAP_W, CNT_W, SUM_W).
- Sub-module channel_history: one channel's ring, pointer, count and sum, with a combinational tap read. It is generated NUM_CHANNELS times.
- Top level: channel decode, response muxing and output registers.

Test Plan:
- Reset, then write ch3 values 1..5 -> read ch3 tap0=5, tap4=1 with rd_miss=0; tap5 gives rd_miss=1, rd_data=0; sum query ch3 returns 15, count 5.
- Write ch0 values 1..12 (DEPTH=10) -> count=10, sum=75 (3..12); tap9=3, tap0=12; pointer wraps correctly.
- Same cycle: write ch2 value 7 and read ch2 tap0 -> response shows the previous newest sample; a read next cycle returns 7.
- Same cycle: clear ch1 and write ch1 value 9, plus a separate write ch4 value 6 -> ch1 count=0, sum=0; ch4 count=1, sum=6.
- Write with in_channel=15 and read ch15 -> no state change in any channel; rd_miss=1; sum query returns 0/0.
- Assert reset for one cycle between an rd_req and its response -> rd_valid=0 the following cycle; all counts 0 afterwards.

Source files
------------

// File: rtl/multichannel_history_pkg.sv
// Shared width helpers and default sizing for the multichannel sample history.
package multichannel_history_pkg;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    localparam int unsigned DEF_NUM_CHANNELS = 14;
    localparam int unsigned DEF_SAMPLE_WIDTH = 8;
    localparam int unsigned DEF_DEPTH        = 10;

    localparam int unsigned DEF_CH_W  = clog2_min1(DEF_NUM_CHANNELS);
    localparam int unsigned DEF_TAP_W = clog2_min1(DEF_DEPTH);
    localparam int unsigned DEF_CNT_W = clog2_min1(DEF_DEPTH + 1);
    localparam int unsigned DEF_SUM_W = DEF_SAMPLE_WIDTH + DEF_CNT_W;

endpackage

// File: rtl/multichannel_sample_history_channel.sv
// One channel's circular history: ring storage, write pointer, fill count and running
// window sum, plus a combinational tap lookup (tap 0 = newest sample).
module channel_history
    import multichannel_history_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    localparam int unsigned TAP_W       = clog2_min1(DEPTH),
    localparam int unsigned CNT_W       = clog2_min1(DEPTH + 1),
    localparam int unsigned SUM_W       = SAMPLE_WIDTH + CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    clr,
    input  logic [SAMPLE_WIDTH-1:0] wr_sample,
    input  logic [TAP_W-1:0]        rd_tap,
    output logic [SAMPLE_WIDTH-1:0] rd_sample_c,
    output logic                    rd_hit_c,
    output logic [CNT_W-1:0]        count,
    output logic [SUM_W-1:0]        sum
);

    logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
    logic [TAP_W-1:0]        wr_ptr;
    logic [SAMPLE_WIDTH-1:0] evict_c;
    logic [TAP_W-1:0]        tap_lim_c;
    logic [TAP_W:0]          idx_base_c;
    logic [TAP_W-1:0]        idx_c;

    assign evict_c = mem[wr_ptr];

    // Pointer, fill level and sum; clear wins over a coincident write.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            count  <= '0;
            sum    <= '0;
        end else if (wr_en) begin
            wr_ptr <= (wr_ptr == TAP_W'(DEPTH - 1)) ? '0 : wr_ptr + TAP_W'(1);
            if (count < CNT_W'(DEPTH)) begin
                count <= count + CNT_W'(1);
                sum   <= sum + SUM_W'(wr_sample);
            end else begin
                sum   <= sum - SUM_W'(evict_c) + SUM_W'(wr_sample);
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !clr && !reset) begin
            mem[wr_ptr] <= wr_sample;
        end
    end

    // Age-to-slot mapping: (wr_ptr - 1 - tap) mod DEPTH, kept non-negative by adding DEPTH.
    always_comb begin
        rd_hit_c   = (CNT_W'(rd_tap) < count);
        tap_lim_c  = rd_hit_c ? rd_tap : '0;
        idx_base_c = (TAP_W+1)'(wr_ptr) + (TAP_W+1)'(DEPTH - 1) - (TAP_W+1)'(tap_lim_c);
        if (idx_base_c >= (TAP_W+1)'(DEPTH)) begin
            idx_c = TAP_W'(idx_base_c - (TAP_W+1)'(DEPTH));
        end else begin
            idx_c = TAP_W'(idx_base_c);
        end
        rd_sample_c = mem[idx_c];
    end

endmodule

// File: rtl/multichannel_sample_history.sv
// Per-channel sample history with registered tap-read and window-sum query ports
// and per-channel clear.
module multichannel_sample_history
    import multichannel_history_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    localparam int unsigned CH_W        = clog2_min1(NUM_CHANNELS),
    localparam int unsigned TAP_W       = clog2_min1(DEPTH),
    localparam int unsigned CNT_W       = clog2_min1(DEPTH + 1),
    localparam int unsigned SUM_W       = SAMPLE_WIDTH + CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [CH_W-1:0]         in_channel,
    input  logic [SAMPLE_WIDTH-1:0] in_sample,
    input  logic                    clr_valid,
    input  logic [CH_W-1:0]         clr_channel,
    input  logic                    rd_req,
    input  logic [CH_W-1:0]         rd_channel,
    input  logic [TAP_W-1:0]        rd_tap,
    output logic                    rd_valid,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic                    rd_miss,
    input  logic                    sum_req,
    input  logic [CH_W-1:0]         sum_channel,
    output logic                    sum_valid,
    output logic [SUM_W-1:0]        sum_data,
    output logic [CNT_W-1:0]        sum_count
);

    logic [SAMPLE_WIDTH-1:0] ch_data  [NUM_CHANNELS];
    logic                    ch_hit   [NUM_CHANNELS];
    logic [CNT_W-1:0]        ch_count [NUM_CHANNELS];
    logic [SUM_W-1:0]        ch_sum   [NUM_CHANNELS];

    logic                    sel_hit_c;
    logic [SAMPLE_WIDTH-1:0] sel_data_c;
    logic [CNT_W-1:0]        sel_count_c;
    logic [SUM_W-1:0]        sel_sum_c;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        channel_history #(
            .SAMPLE_WIDTH(SAMPLE_WIDTH),
            .DEPTH       (DEPTH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (in_valid && (in_channel == CH_W'(g))),
            .clr        (clr_valid && (clr_channel == CH_W'(g))),
            .wr_sample  (in_sample),
            .rd_tap     (rd_tap),
            .rd_sample_c(ch_data[g]),
            .rd_hit_c   (ch_hit[g]),
            .count      (ch_count[g]),
            .sum        (ch_sum[g])
        );
    end

    // Channel select; an out-of-range channel matches nothing and yields miss / 0 / 0.
    always_comb begin
        sel_hit_c   = 1'b0;
        sel_data_c  = '0;
        sel_count_c = '0;
        sel_sum_c   = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (rd_channel == CH_W'(c)) begin
                sel_hit_c  = ch_hit[c];
                sel_data_c = ch_data[c];
            end
            if (sum_channel == CH_W'(c)) begin
                sel_count_c = ch_count[c];
                sel_sum_c   = ch_sum[c];
            end
        end
    end

    // Response registers; data holds between responses, strobes qualify.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_miss   <= 1'b0;
            sum_valid <= 1'b0;
            sum_data  <= '0;
            sum_count <= '0;
        end else begin
            rd_valid  <= rd_req;
            sum_valid <= sum_req;
            if (rd_req) begin
                rd_data <= sel_hit_c ? sel_data_c : '0;
                rd_miss <= !sel_hit_c;
            end
            if (sum_req) begin
                sum_data  <= sel_sum_c;
                sum_count <= sel_count_c;
            end
        end
    end

endmodule
